uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Frame format is 8N1: start, 8 data bits LSB first, stop.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Power-of-two depth; pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; push+pop together keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter.
// tx is a flop; stop-end pops go straight to START.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    tx_state_t      state;
    logic [CW-1:0]  baud;
    logic [IW-1:0]  bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     head;
    logic           full;
    logic           empty;
    logic           pop;
    logic           bit_end;

    assign bit_end  = (baud == '0);
    assign wr_ready = !full;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign pop      = !empty &&
                      ((state == IDLE) ||
                       (state == STOP && bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid),
        .din   (wr_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Transmit FSM: baud countdown, bit shifting, registered tx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= IDLE_LEVEL;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (pop) begin
                        shreg <= head;
                        baud  <= BAUD_MAX;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= BAUD_MAX;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= BAUD_MAX;
                        if (bit_idx == LAST_BIT) begin
                            tx    <= IDLE_LEVEL;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shreg <= head;
                            baud  <= BAUD_MAX;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a mid-bit UART receiver.
// CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int DEP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int frames = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Receiver: detect start, sample every bit at its middle.
    bit         rx_busy = 0;
    int         ph = 0;
    int         k = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (tx == 1'b0) begin
                rx_busy = 1;
                ph = 1;
                k = 0;
                frames++;
                start_q.push_back(cyc);
            end
        end else begin
            ph--;
            if (ph == 0) begin
                if (k == 0) begin
                    chk("start_bit", int'(tx), 0);
                end else if (k <= 8) begin
                    rx_byte[k-1] = tx;
                end else begin
                    chk("stop_bit", int'(tx), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", int'(rx_byte), -1);
                    end else begin
                        chk("rx_byte", int'(rx_byte),
                            int'(exp_q.pop_front()));
                    end
                    rx_busy = 0;
                end
                k++;
                ph = CPB;
            end
        end
    end

    task automatic wr_exp(input logic [7:0] b, input bit acc);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        chk("wr_ready", int'(wr_ready), int'(acc));
        @(posedge clk);
        if (acc) exp_q.push_back(b);
    endtask

    task automatic wr_any(input logic [7:0] b);
        bit acc;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        acc = wr_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || rx_busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", int'(n < 5000), 1);
    endtask

    initial begin
        int e0;
        int n;
        int base;
        int sent;

        // Reset values, asserted from time zero.
        #23;
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(wr_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("post_rst_count", int'(fifo_count), 0);

        // Single byte 0x41 from idle.
        start_q.delete();
        wr_exp(8'h41, 1);
        #1 e0 = cyc;
        idle(1);
        while (cyc < e0 + 40) @(negedge clk);
        chk("busy_at_e40", int'(busy), 1);
        @(negedge clk);
        chk("busy_at_e41", int'(busy), 0);
        drain();
        chk("start_latency", start_q.size() > 0 ? start_q[0] : -1, e0 + 1);

        // Two bytes back to back.
        start_q.delete();
        wr_exp(8'h48, 1);
        #1 e0 = cyc;
        wr_exp(8'h69, 1);
        idle(1);
        while (cyc < e0 + 80) @(negedge clk);
        chk("busy_at_e80", int'(busy), 1);
        @(negedge clk);
        chk("busy_at_e81", int'(busy), 0);
        drain();
        chk("b2b_frames", start_q.size(), 2);
        if (start_q.size() == 2)
            chk("b2b_gap", start_q[1] - start_q[0], 10 * CPB);

        // Nine writes fill the FIFO; tenth dropped; hold until ready.
        for (int i = 0; i < 9; i++) wr_exp(8'h10 + 8'(i), 1);
        wr_exp(8'hEE, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("full_count", int'(fifo_count), DEP);
        chk("full_ready", int'(wr_ready), 0);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        n = 0;
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_in_time", int'(n < 200), 1);
        @(posedge clk);
        exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("refill_count", int'(fifo_count), DEP);
        drain();

        // Reset during the second of three queued frames.
        base = frames;
        wr_exp(8'hC3, 1);
        wr_exp(8'h5A, 1);
        wr_exp(8'h0F, 1);
        idle(1);
        n = 0;
        while (frames < base + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("second_frame_seen", frames - base, 2);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(wr_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = frames;
        repeat (100) @(negedge clk);
        chk("no_frame_after_rst", frames - base, 0);
        chk("idle_tx_after_rst", int'(tx), 1);
        chk("idle_busy_after_rst", int'(busy), 0);

        // Random bursts, 200 accepted bytes.
        sent = 0;
        while (sent < 200) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n && sent < 200; i++) begin
                base = exp_q.size();
                wr_any(8'($urandom));
                if (exp_q.size() != base) sent++;
            end
            idle($urandom_range(1, 60));
        end
        drain();
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
